// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encoding and the default operand width.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_carry_cell.sv
// Single-bit CLA carry cell: generate, or propagate an incoming carry.
module serial_add_ctrl_carry_cell (
  input  logic p,
  input  logic g,
  input  logic cin,
  output logic cout
);

  assign cout = g | (p & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine with a valid/ready front end. It processes one
// bit per cycle, LSB first, and holds the result until the consumer takes it.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_s;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             p_s;
  logic             g_s;
  logic             carry_next_s;
  logic             last_s;
  logic             accept_s;

  assign p_s      = a_r[cnt_r] ^ b_r[cnt_r];
  assign g_s      = a_r[cnt_r] & b_r[cnt_r];
  assign last_s   = (cnt_r == LAST_BIT);
  assign accept_s = (state_r == ST_IDLE) && in_valid && !flush;

  serial_add_ctrl_carry_cell u_carry (
    .p   (p_s),
    .g   (g_s),
    .cin (carry_r),
    .cout(carry_next_s)
  );

  // Working result with the current bit inserted.
  always_comb begin
    acc_s        = acc_r;
    acc_s[cnt_r] = p_s ^ carry_r;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; flush overrides every other transition.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) state_s = ST_RUN;
          else          state_s = ST_IDLE;
        end
        ST_RUN: begin
          if (last_s) state_s = ST_DONE;
          else        state_s = ST_RUN;
        end
        ST_DONE: begin
          if (out_ready) state_s = ST_IDLE;
          else           state_s = ST_DONE;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // FSM output decode.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand, carry, counter and result registers. Subtraction is a + ~b + 1,
  // with the +1 entering as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (flush) begin
      cnt_r   <= '0;
      carry_r <= 1'b0;
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= sub;
      cnt_r   <= '0;
    end else if (state_r == ST_RUN) begin
      acc_r   <= acc_s;
      carry_r <= carry_next_s;
      if (last_s) begin
        // Publish the whole word at once so outputs never show a partial result.
        sum_r  <= acc_s;
        cout_r <= carry_next_s;
        ovf_r  <= carry_r ^ carry_next_s;
      end else begin
        cnt_r  <= cnt_r + 1'b1;
      end
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed corner cases plus random
// operations, checked against an integer-arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  res_t         exp_q[$];
  res_t         mon_e;
  res_t         hold_e;
  logic [W-1:0] last_sum;
  int           total = 0;
  int           bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t m;
    int   ux, uy, sx, sy, sr;
    int   smax, smin;
    ux   = int'(x);
    uy   = int'(y);
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    if (s) begin
      m.sum  = W'(ux - uy);
      m.cout = (ux >= uy) ? 1'b1 : 1'b0;
      sr     = sx - sy;
    end else begin
      m.sum  = W'(ux + uy);
      m.cout = ((ux + uy) >= (1 << W)) ? 1'b1 : 1'b0;
      sr     = sx + sy;
    end
    m.ovf = ((sr > smax) || (sr < smin)) ? 1'b1 : 1'b0;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: pops the scoreboard on every completed hand-off.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=%0h required=none", sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(mon_e.sum));
        chk("sb_cout", 32'(cout), 32'(mon_e.cout));
        chk("sb_ovf", 32'(ovf), 32'(mon_e.ovf));
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("issue_timeout", 32'(n), 32'(0));
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    step();
    in_valid = 1'b0;
    if (push) exp_q.push_back(model(x, y, s));
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 4 * W) begin
      step();
      k++;
      if (k == 1) begin
        chk("run_busy", 32'(busy), 32'(1));
        chk("run_in_ready", 32'(in_ready), 32'(0));
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int stall);
    int k;
    issue(x, y, s, 1'b1);
    wait_valid(k);
    chk("latency", 32'(k), 32'(W));
    repeat (stall) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    last_sum = model(x, y, s).sum;
  endtask

  task automatic expect_quiet(input string name);
    int hits;
    hits = 0;
    repeat (3 * W) begin
      step();
      if (out_valid) hits++;
    end
    chk(name, 32'(hits), 32'(0));
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    last_sum  = '0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout_ovf", 32'({cout, ovf}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 2);
    run_op(16'h8000, 16'h0001, 1'b1, 0);

    // Stall in DONE with a competing request pending.
    issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
    hold_e = model(16'hA5A5, 16'h5A5A, 1'b1);
    wait_valid(k);
    chk("stall_latency", 32'(k), 32'(W));
    in_valid = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    repeat (5) begin
      step();
      chk("stall_sum", 32'(sum), 32'(hold_e.sum));
      chk("stall_flags", 32'({cout, ovf}), 32'({hold_e.cout, hold_e.ovf}));
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_out_valid", 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("release_in_ready", 32'(in_ready), 32'(1));
    chk("release_busy", 32'(busy), 32'(0));
    step();
    chk("no_second_accept", 32'(busy), 32'(0));
    chk("retain_sum", 32'(sum), 32'(hold_e.sum));

    // Reset eight edges after accept.
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", 32'(sum), 32'(0));
    chk("midrst_flags", 32'({cout, ovf}), 32'(0));
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    last_sum = '0;
    step();
    chk("postrst_in_ready", 32'(in_ready), 32'(1));
    expect_quiet("postrst_no_valid");

    // Flush five edges after accept.
    issue(16'h3333, 16'h4444, 1'b0, 1'b0);
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'(0));
    chk("flush_in_ready", 32'(in_ready), 32'(1));
    chk("flush_sum_kept", 32'(sum), 32'(last_sum));
    expect_quiet("flush_no_valid");
    run_op(16'h0001, 16'h0001, 1'b0, 0);
    chk("after_flush_sum", 32'(sum), 32'(2));

    // Flush in IDLE only blocks acceptance.
    flush = 1'b1;
    in_valid = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("idle_flush_no_accept", 32'(busy), 32'(0));

    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair a/b/sub presented.
REQ-005 in_ready  output  1  block idle and able to accept an operand pair.
REQ-006 a  input  WIDTH  operand A, unsigned/two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 sub  input  1  1 = compute a-b, 0 = compute a+b.
REQ-009 flush  input  1  synchronous abort; returns to IDLE and discards the operation.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result word.
REQ-013 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 ovf  output  1  signed overflow (carry into MSB xor carry out of MSB).
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE -> RUN on in_valid & in_ready: latch a, latch (sub ? ~b : b), carry register <= sub, bit counter <= 0.
REQ-018 Each RUN cycle SHALL process one bit i = counter: p = a[i]^b'[i], g = a[i]&b'[i], sum[i] <= p^carry, carry <= g | (p & carry).
REQ-019 The carry update SHALL come from a single shared carry-cell instance; no other carry path exists.
REQ-020 RUN -> DONE on the edge that processes bit WIDTH-1; counter SHALL NOT wrap past WIDTH-1.
REQ-021 Latency: accept on edge t, out_valid SHALL rise after edge t+WIDTH, exactly WIDTH cycles.
REQ-022 On the bit WIDTH-1 edge, the block SHALL register ovf = carry_in(MSB) ^ carry_out(MSB) and cout = carry_out(MSB).
REQ-023 DONE -> IDLE on out_valid & out_ready; sum/cout/ovf SHALL hold stable while out_ready = 0.
REQ-024 in_valid SHALL be ignored outside IDLE; no overlap between result hand-off and new accept (accept earliest on edge after hand-off).
REQ-025 sum/cout/ovf SHALL retain the last result in IDLE until the next result is written.
REQ-026 flush = 1 in any state SHALL force IDLE on the next edge, clear counter and carry, and deassert out_valid; flush has priority over in_valid and out_ready.
REQ-027 flush in IDLE SHALL have no effect other than blocking acceptance that cycle.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0, busy 0, in_ready 1.
REQ-029 Reset mid-RUN or mid-DONE SHALL discard the operation; no result is emitted after release.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-031 One sub-module SHALL be instantiated: the team's CLA carry cell (ports p, g, cin, cout; cout = g | (p & cin)).
REQ-032 Counter width SHALL be clog2(WIDTH); operand shift/index logic stays in serial_add_ctrl.

Verification
REQ-033 a=0x1234, b=0x4321, sub=0 -> sum=0x5555, cout=0, ovf=0, out_valid exactly 16 cycles after accept.
REQ-034 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-035 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> sum/cout/ovf stable, in_ready=0, no second accept; release -> IDLE next edge.
REQ-037 Assert rst_n=0 at accept+8 -> all outputs at reset values immediately, in_ready=1 after release, no out_valid.
REQ-038 Pulse flush at accept+5 -> IDLE next edge, out_valid never asserted; following op 0x0001+0x0001 -> sum=0x0002.
